note_count_glider: RTL and testbench

Upstream control stage for the 32-bit arbitrary clock divider. It accepts note requests over a valid/ready handshake and maps each 3-bit note index to a half-period divider count for a 50 MHz clock. It either applies the new count immediately or slews (glides) the count toward it in fixed steps at a fixed tick rate. Its `div_clk_count` output drives the divider's count input directly, and the divider toggles its output every `div_clk_count` input clocks.

---
 rtl/tone_pkg.sv | 27 ++
 rtl/glide_tick.sv | 46 ++++
 rtl/note_count_glider.sv | 121 ++++++++++++
 tb/tb_note_count_glider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// ============================================================================
// Module      : tone_pkg
// Description : Note table, state encoding and widths shared by the glider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_pkg;

    localparam int COUNT_W = 32;

    // Half-period counts for a 50 MHz clock, Do5 through Do6
    localparam logic [COUNT_W-1:0] NOTE_COUNT [0:7] = '{
        32'd47801, 32'd42589, 32'd37936, 32'd35816,
        32'd31887, 32'd28409, 32'd25303, 32'd23900
    };

    localparam logic [COUNT_W-1:0] RESET_COUNT = 32'd47801;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GLIDE = 1'b1
    } glide_state_t;

endpackage

`default_nettype wire

// File: rtl/glide_tick.sv
// ============================================================================
// Module      : glide_tick
// Description : GLIDE_PERIOD prescaler producing a registered one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module glide_tick #(
    parameter int unsigned GLIDE_PERIOD = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick_o
);

    localparam logic [31:0] c_last = 32'(GLIDE_PERIOD - 1);

    logic [31:0] r_tick;
    logic        r_tick_o;
    logic        w_wrap;

    assign w_wrap = (r_tick == c_last);

    // The pulse is registered, so a step lands one edge after the wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick   <= '0;
            r_tick_o <= 1'b0;
        end else if (clr) begin
            r_tick   <= '0;
            r_tick_o <= 1'b0;
        end else if (en) begin
            r_tick   <= w_wrap ? '0 : r_tick + 32'd1;
            r_tick_o <= w_wrap;
        end else begin
            r_tick_o <= 1'b0;
        end
    end

    assign tick_o = r_tick_o;

endmodule

`default_nettype wire

// File: rtl/note_count_glider.sv
// ============================================================================
// Module      : note_count_glider
// Description : Maps note requests to divider counts, jumping or gliding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_count_glider
    import tone_pkg::*;
#(
    parameter int unsigned          CLK_HZ       = 50_000_000,
    parameter int unsigned          GLIDE_PERIOD = 50_000,
    parameter logic [COUNT_W-1:0]   GLIDE_STEP   = 32'd64
) (
    input  logic               inclk,
    input  logic               reset,
    input  logic [2:0]         note_sel,
    input  logic               note_valid,
    input  logic               glide_en,
    output logic               note_ready,
    output logic [COUNT_W-1:0] div_clk_count,
    output logic               count_changed,
    output logic               gliding
);

    if ((CLK_HZ == 0) || (GLIDE_PERIOD == 0) || (GLIDE_STEP == '0)) begin : g_param_check
        $error("note_count_glider: CLK_HZ, GLIDE_PERIOD and GLIDE_STEP must be nonzero");
    end

    glide_state_t       r_state;
    glide_state_t       w_next_state;
    logic [COUNT_W-1:0] r_cur;
    logic [COUNT_W-1:0] r_tgt;
    logic               r_changed;

    logic [COUNT_W-1:0] w_tbl;
    logic               w_accept;
    logic               w_jump;
    logic               w_start;
    logic               w_tick;
    logic               w_step;
    logic               w_up;
    logic [COUNT_W-1:0] w_diff;
    logic [COUNT_W-1:0] w_delta;
    logic [COUNT_W-1:0] w_stepped;

    assign w_tbl    = NOTE_COUNT[note_sel];
    assign w_accept = note_valid && (r_state == IDLE);
    // A glide toward the current value would never take a step, so treat it as a jump
    assign w_jump   = w_accept && (!glide_en || (w_tbl == r_cur));
    assign w_start  = w_accept && !w_jump;
    assign w_step   = (r_state == GLIDE) && w_tick;

    assign w_up      = (r_tgt >= r_cur);
    assign w_diff    = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);
    assign w_delta   = (w_diff < GLIDE_STEP) ? w_diff : GLIDE_STEP;
    assign w_stepped = w_up ? (r_cur + w_delta) : (r_cur - w_delta);

    glide_tick #(
        .GLIDE_PERIOD (GLIDE_PERIOD)
    ) u_glide_tick (
        .clk    (inclk),
        .reset  (reset),
        .clr    (w_start),
        .en     (r_state == GLIDE),
        .tick_o (w_tick)
    );

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = GLIDE;
            GLIDE:   if (w_step && (w_stepped == r_tgt)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        note_ready = 1'b0;
        gliding    = 1'b0;
        case (r_state)
            IDLE:    note_ready = 1'b1;
            GLIDE:   gliding    = 1'b1;
            default: note_ready = 1'b1;
        endcase
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            r_cur     <= RESET_COUNT;
            r_tgt     <= RESET_COUNT;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_accept) begin
                r_tgt <= w_tbl;
            end
            if (w_jump) begin
                r_cur     <= w_tbl;
                r_changed <= (w_tbl != r_cur);
            end else if (w_step) begin
                r_cur     <= w_stepped;
                r_changed <= 1'b1;
            end
        end
    end

    assign div_clk_count = r_cur;
    assign count_changed = r_changed;

endmodule

`default_nettype wire

// File: tb/tb_note_count_glider.sv
// ============================================================================
// Module      : tb_note_count_glider
// Description : Directed self-checking bench for note_count_glider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_count_glider;

    logic        inclk = 1'b0;
    logic        reset;
    logic [2:0]  note_sel;
    logic        note_valid;
    logic        glide_en;
    logic        note_ready;
    logic [31:0] div_clk_count;
    logic        count_changed;
    logic        gliding;

    int checks   = 0;
    int failures = 0;

    always #5 inclk = ~inclk;

    note_count_glider #(
        .CLK_HZ       (50_000_000),
        .GLIDE_PERIOD (4),
        .GLIDE_STEP   (32'd1000)
    ) dut (
        .inclk         (inclk),
        .reset         (reset),
        .note_sel      (note_sel),
        .note_valid    (note_valid),
        .glide_en      (glide_en),
        .note_ready    (note_ready),
        .div_clk_count (div_clk_count),
        .count_changed (count_changed),
        .gliding       (gliding)
    );

    // One-cycle request; returns on the negedge after the accepting edge
    task automatic request(input logic [2:0] sel, input logic ge);
        @(negedge inclk);
        note_sel   = sel;
        glide_en   = ge;
        note_valid = 1'b1;
        @(negedge inclk);
        note_valid = 1'b0;
    endtask

    task automatic test_reset;
        int pulses = 0;
        reset      = 1'b1;
        note_valid = 1'b0;
        note_sel   = 3'd0;
        glide_en   = 1'b0;
        repeat (3) @(negedge inclk);
        reset = 1'b0;
        checks++; if (div_clk_count !== 32'd47801) begin failures++; $display("FAIL reset_count got=%0d exp=47801", div_clk_count); end
        checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", note_ready); end
        checks++; if (gliding !== 1'b0) begin failures++; $display("FAIL reset_gliding got=%b exp=0", gliding); end
        checks++; if (count_changed !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", count_changed); end
        repeat (20) begin
            @(negedge inclk);
            if (count_changed) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
        checks++; if (div_clk_count !== 32'd47801) begin failures++; $display("FAIL idle_count got=%0d exp=47801", div_clk_count); end
    endtask

    task automatic test_jump;
        int pulses = 0;
        request(3'd7, 1'b0);
        checks++; if (div_clk_count !== 32'd23900) begin failures++; $display("FAIL jump_count got=%0d exp=23900", div_clk_count); end
        checks++; if (count_changed !== 1'b1) begin failures++; $display("FAIL jump_changed got=%b exp=1", count_changed); end
        checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL jump_ready got=%b exp=1", note_ready); end
        checks++; if (gliding !== 1'b0) begin failures++; $display("FAIL jump_gliding got=%b exp=0", gliding); end
        repeat (10) begin
            @(negedge inclk);
            if (count_changed) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL jump_extra_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_glide;
        logic [31:0] exp_vals [0:5] = '{32'd46801, 32'd45801, 32'd44801, 32'd43801, 32'd42801, 32'd42589};
        int n = 0;
        request(3'd0, 1'b0);
        checks++; if (div_clk_count !== 32'd47801) begin failures++; $display("FAIL glide_prejump got=%0d exp=47801", div_clk_count); end
        request(3'd1, 1'b1);
        checks++; if (gliding !== 1'b1) begin failures++; $display("FAIL glide_start_gliding got=%b exp=1", gliding); end
        checks++; if (note_ready !== 1'b0) begin failures++; $display("FAIL glide_start_ready got=%b exp=0", note_ready); end
        for (int idx = 0; idx < 60 && n < 6; idx++) begin
            if (idx > 0) @(negedge inclk);
            if (idx == 2) glide_en = 1'b0;
            if (count_changed) begin
                checks++; if (div_clk_count !== exp_vals[n]) begin failures++; $display("FAIL glide_step%0d got=%0d exp=%0d", n, div_clk_count, exp_vals[n]); end
                checks++; if (idx !== 5 + 4 * n) begin failures++; $display("FAIL glide_step%0d_time got=%0d exp=%0d", n, idx, 5 + 4 * n); end
                checks++; if (gliding !== (n < 5)) begin failures++; $display("FAIL glide_step%0d_gliding got=%b exp=%b", n, gliding, (n < 5)); end
                n++;
            end
        end
        checks++; if (n !== 6) begin failures++; $display("FAIL glide_pulses got=%0d exp=6", n); end
        checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL glide_end_ready got=%b exp=1", note_ready); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_a [0:5] = '{32'd46801, 32'd45801, 32'd44801, 32'd43801, 32'd42801, 32'd42589};
        logic [31:0] exp_v;
        int n        = 0;
        int acc_idx  = -1;
        int last_idx = -1;
        request(3'd0, 1'b0);
        @(negedge inclk);
        note_sel   = 3'd1;
        glide_en   = 1'b1;
        note_valid = 1'b1;
        @(negedge inclk);
        note_sel = 3'd5;
        for (int idx = 0; idx < 200 && n < 21; idx++) begin
            if (idx > 0) @(negedge inclk);
            if (count_changed) begin
                if (n < 6)       exp_v = exp_a[n];
                else if (n < 20) exp_v = 32'd42589 - 32'(1000 * (n - 5));
                else             exp_v = 32'd28409;
                checks++; if (div_clk_count !== exp_v) begin failures++; $display("FAIL b2b_step%0d got=%0d exp=%0d", n, div_clk_count, exp_v); end
                n++;
                last_idx = idx;
            end
            if (n == 6 && acc_idx < 0 && gliding) begin
                acc_idx    = idx;
                note_valid = 1'b0;
            end
        end
        note_valid = 1'b0;
        checks++; if (acc_idx !== 26) begin failures++; $display("FAIL b2b_accept_time got=%0d exp=26", acc_idx); end
        checks++; if (n !== 21) begin failures++; $display("FAIL b2b_pulses got=%0d exp=21", n); end
        checks++; if (last_idx !== 87) begin failures++; $display("FAIL b2b_last_time got=%0d exp=87", last_idx); end
        checks++; if (div_clk_count !== 32'd28409) begin failures++; $display("FAIL b2b_final got=%0d exp=28409", div_clk_count); end
        checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", note_ready); end
    endtask

    task automatic test_same_note;
        int pulses = 0;
        request(3'd0, 1'b0);
        checks++; if (div_clk_count !== 32'd47801) begin failures++; $display("FAIL same_prejump got=%0d exp=47801", div_clk_count); end
        request(3'd0, 1'b1);
        checks++; if (gliding !== 1'b0) begin failures++; $display("FAIL same_gliding got=%b exp=0", gliding); end
        checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%b exp=1", note_ready); end
        checks++; if (count_changed !== 1'b0) begin failures++; $display("FAIL same_changed got=%b exp=0", count_changed); end
        repeat (10) begin
            @(negedge inclk);
            if (count_changed || gliding) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL same_activity got=%0d exp=0", pulses); end
    endtask

    task automatic test_mid_reset;
        int n      = 0;
        int pulses = 0;
        request(3'd7, 1'b1);
        for (int idx = 0; idx < 40 && n < 2; idx++) begin
            if (idx > 0) @(negedge inclk);
            if (count_changed) n++;
        end
        checks++; if (div_clk_count !== 32'd45801) begin failures++; $display("FAIL midrst_pre got=%0d exp=45801", div_clk_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (div_clk_count !== 32'd47801) begin failures++; $display("FAIL midrst_count got=%0d exp=47801", div_clk_count); end
        checks++; if (gliding !== 1'b0) begin failures++; $display("FAIL midrst_gliding got=%b exp=0", gliding); end
        checks++; if (note_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", note_ready); end
        checks++; if (count_changed !== 1'b0) begin failures++; $display("FAIL midrst_changed got=%b exp=0", count_changed); end
        repeat (3) @(negedge inclk);
        reset = 1'b0;
        repeat (30) begin
            @(negedge inclk);
            if (count_changed || gliding) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_after got=%0d exp=0", pulses); end
        checks++; if (div_clk_count !== 32'd47801) begin failures++; $display("FAIL midrst_final got=%0d exp=47801", div_clk_count); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_glide();
        test_back_to_back();
        test_same_note();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
